// File: rtl/booth_divider_seq_if.sv
// Start/busy/done handshake bundle for booth_divider_seq.
// BOOTH_DIV_OVF_FLAG_EN adds the MIN/-1 overflow flag.
interface booth_divider_seq_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
`ifdef BOOTH_DIV_OVF_FLAG_EN
  logic             overflow;

  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, div_by_zero, overflow);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero, overflow);
`else
  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, div_by_zero);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero);
`endif
endinterface

// File: rtl/booth_divider_seq.sv
// Sequential signed divider: radix-2 restoring division on magnitudes, then sign fix.
// Optional macro BOOTH_DIV_OVF_FLAG_EN enables the overflow output for MIN / -1.
module booth_divider_seq #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  booth_divider_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] p;     // partial remainder magnitude
  logic [WIDTH-1:0] q;     // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dmag;
  logic             sa, sb, dz;
  logic [WIDTH:0]   p_sh;
  logic [WIDTH-1:0] p_sub;
  logic             ge;
  logic             accept;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign accept = (state == IDLE) && bus.start;

  // True difference is below dmag, so the low WIDTH bits hold it exactly.
  assign p_sh  = {p, q[WIDTH-1]};
  assign ge    = p_sh >= {1'b0, dmag};
  assign p_sub = p_sh[WIDTH-1:0] - dmag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = (bus.divisor == '0) ? FIX : CALC;
      CALC: if (cnt == '0) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

`ifdef BOOTH_DIV_OVF_FLAG_EN
  logic ovf_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_c        <= 1'b0;
      bus.overflow <= 1'b0;
    end else if (accept) begin
      ovf_c        <= (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.divisor == '1);
      bus.overflow <= 1'b0;
    end else if (state == FIX) begin
      bus.overflow <= ovf_c;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= '0;
      p               <= '0;
      q               <= '0;
      dmag            <= '0;
      sa              <= 1'b0;
      sb              <= 1'b0;
      dz              <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          sa              <= bus.dividend[WIDTH-1];
          sb              <= bus.divisor[WIDTH-1];
          q               <= mag(bus.dividend);
          dmag            <= mag(bus.divisor);
          p               <= '0;
          cnt             <= CW'(WIDTH-1);
          dz              <= (bus.divisor == '0);
          bus.div_by_zero <= 1'b0;
        end
        CALC: begin
          p   <= ge ? p_sub : p_sh[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], ge};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          // With a zero divisor q still holds |dividend|, so the remainder rebuilds the dividend.
          if (dz) begin
            bus.quotient    <= '1;
            bus.remainder   <= sa ? -q : q;
            bus.div_by_zero <= 1'b1;
          end else begin
            bus.quotient    <= (sa ^ sb) ? -q : q;
            bus.remainder   <= sa ? -p : p;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_divider_seq.sv
// Directed bench for booth_divider_seq: per-cycle compare against a behavioural model,
// plus literal expectations for the hand-worked vectors.
module tb_booth_divider_seq;
  localparam int W = 64;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  booth_divider_seq_if #(.WIDTH(W)) bus();
  booth_divider_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 working, 2 done cycle; held_* are the visible results.
  int               m_phase = 0;
  int               m_left  = 0;
  logic [W-1:0]     held_q = '0, held_r = '0;
  logic             held_dz = 1'b0, held_ovf = 1'b0;
  logic [W-1:0]     p_q, p_r;
  logic             p_dz, p_ovf;
  logic signed [W-1:0] ma, mb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_left = 0;
      held_q = '0; held_r = '0; held_dz = 1'b0; held_ovf = 1'b0;
    end else begin
      case (m_phase)
        0: if (bus.start) begin
          ma = bus.dividend; mb = bus.divisor;
          p_dz = 1'b0; p_ovf = 1'b0;
          if (mb == 0) begin
            p_q = '1; p_r = ma; p_dz = 1'b1;
          end else if (ma == MIN && mb == -1) begin
            p_q = MIN; p_r = '0; p_ovf = 1'b1;
          end else begin
            p_q = ma / mb; p_r = ma % mb;
          end
          held_dz = 1'b0; held_ovf = 1'b0;
          m_left  = (mb == 0) ? 1 : W + 1;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 2;
            held_q = p_q; held_r = p_r; held_dz = p_dz; held_ovf = p_ovf;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("busy", W'(bus.busy), W'(m_phase != 0));
    check("done", W'(bus.done), W'(m_phase == 2));
    check("quotient", bus.quotient, held_q);
    check("remainder", bus.remainder, held_r);
    check("div_by_zero", W'(bus.div_by_zero), W'(held_dz));
`ifdef BOOTH_DIV_OVF_FLAG_EN
    check("overflow", W'(bus.overflow), W'(held_ovf));
`endif
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz, input logic eovf, input int elat, input bit poke);
    int  n;
    bit  busy_ok;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.dividend = {$urandom, $urandom};
    bus.divisor  = {$urandom, $urandom};
    n = 0;
    busy_ok = 1'b1;
    while (!bus.done && n < 200) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (poke && n == 10) begin
        bus.start = 1'b1; bus.dividend = 64'd999; bus.divisor = 64'd3;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      n++;
    end
    check("latency", W'(n), W'(elat));
    check("busy_throughout", W'(busy_ok), W'(1));
    check("lit_quotient", bus.quotient, eq);
    check("lit_remainder", bus.remainder, er);
    check("lit_div_by_zero", W'(bus.div_by_zero), W'(edz));
`ifdef BOOTH_DIV_OVF_FLAG_EN
    check("lit_overflow", W'(bus.overflow), W'(eovf));
`else
    if (eovf) n_vec += 0;
`endif
    @(posedge clk); #1;
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
  endtask

  initial begin
    int dn;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", W'(bus.busy), W'(0));
    check("rst_done", W'(bus.done), W'(0));
    check("rst_quotient", bus.quotient, '0);
    check("rst_remainder", bus.remainder, '0);
    check("rst_div_by_zero", W'(bus.div_by_zero), W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(64'd15, 64'd1, 64'd15, 64'd0, 1'b0, 1'b0, W + 1, 1'b0);
    do_op(64'h230, 64'd2, 64'h118, 64'd0, 1'b0, 1'b0, W + 1, 1'b0);
    do_op(64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0, 1'b0, W + 1, 1'b0);
    do_op(-64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, W + 1, 1'b0);
    do_op(-64'sd7, -64'sd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, W + 1, 1'b0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          1'b1, 1'b0, 1, 1'b0);
    do_op(MIN, 64'hFFFF_FFFF_FFFF_FFFF, MIN, 64'd0, 1'b0, 1'b1, W + 1, 1'b0);
    do_op(64'd0, 64'd5, 64'd0, 64'd0, 1'b0, 1'b0, W + 1, 1'b0);
    do_op(64'h7FFF_FFFF_FFFF_FFFF, MIN, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, W + 1, 1'b0);
    do_op(MIN, 64'd1, MIN, 64'd0, 1'b0, 1'b0, W + 1, 1'b0);
    do_op(64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0, 1'b0, W + 1, 1'b0);

    // start during a running division must be ignored
    do_op(-64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, W + 1, 1'b1);
    count_done(80, dn);
    check("no_second_done", W'(dn), W'(0));

    // reset mid-operation abandons the division
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 64'd1000; bus.divisor = 64'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", W'(bus.busy), W'(0));
    check("midrst_done", W'(bus.done), W'(0));
    check("midrst_quotient", bus.quotient, '0);
    check("midrst_remainder", bus.remainder, '0);
    check("midrst_div_by_zero", W'(bus.div_by_zero), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    count_done(80, dn);
    check("no_done_after_rst", W'(dn), W'(0));
    do_op(64'd1000, 64'd3, 64'd333, 64'd1, 1'b0, 1'b0, W + 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
